// File: rtl/macro_lane_arbiter.sv
// macro_lane_arbiter: round-robin arbiter that shares one fixed-latency hard macro among four
// requesters and routes each macro result back to the requester that issued it.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   req_valid[3:0]    per-requester request valid
//   req_data          requester i word in bits [i*DATA_W +: DATA_W]
//   req_ready[3:0]    combinational grant, one-hot or zero
//   m_en, m_in        registered macro input strobe and word
//   m_out             macro result, valid MACRO_LAT cycles after m_en
//   rsp_valid[3:0]    one-cycle response strobe to the issuing requester
//   rsp_data          response word, qualified by rsp_valid
//   drain             level request to stop granting and empty the macro pipeline
//   drain_done        one-cycle pulse once the pipeline is empty
//   busy              not idle, or any transaction still outstanding
module macro_lane_arbiter #(
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned MACRO_LAT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req_valid,
    input  logic [4*DATA_W-1:0]   req_data,
    output logic [3:0]            req_ready,
    output logic                  m_en,
    output logic [DATA_W-1:0]     m_in,
    input  logic [DATA_W-1:0]     m_out,
    output logic [3:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    input  logic                  drain,
    output logic                  drain_done,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(MACRO_LAT + 3);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e             state_q, state_d;
    logic               drain_done_d;
    logic [1:0]         rr_q;
    logic [1:0]         issue_id_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [MACRO_LAT-1:0] tag_v_q;
    logic [1:0]         tag_id_q [MACRO_LAT];

    logic               transfer;
    logic [1:0]         grant_id;
    logic [1:0]         idx;
    logic               sample;
    logic [1:0]         sample_id;

    // Tag pipeline starts one cycle behind m_en, so its last stage lines up with valid m_out.
    assign sample    = tag_v_q[MACRO_LAT-1];
    assign sample_id = tag_id_q[MACRO_LAT-1];

    // Round-robin search starting at rr_q; drain suppresses all grants.
    always_comb begin
        req_ready = '0;
        grant_id  = '0;
        transfer  = 1'b0;
        idx       = '0;
        if (!rst && state_q == StRun && !drain) begin
            for (int k = 0; k < 4; k++) begin
                idx = rr_q + 2'(k);
                if (!transfer && req_valid[idx]) begin
                    transfer = 1'b1;
                    grant_id = idx;
                end
            end
            if (transfer) begin
                req_ready[grant_id] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        drain_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (drain) begin
                    state_d = StDrain;
                end else if (|req_valid) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (drain) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Empty means nothing in the macro and nothing waiting in the response register.
                if (cnt_q == '0 && rsp_valid == '0) begin
                    state_d      = StIdle;
                    drain_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            drain_done <= 1'b0;
            rr_q       <= '0;
            issue_id_q <= '0;
            cnt_q      <= '0;
            m_en       <= 1'b0;
            m_in       <= '0;
            tag_v_q    <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            for (int i = 0; i < int'(MACRO_LAT); i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            drain_done <= drain_done_d;
            m_en       <= transfer;
            if (transfer) begin
                m_in       <= req_data[grant_id*DATA_W +: DATA_W];
                issue_id_q <= grant_id;
                rr_q       <= grant_id + 2'd1;
            end

            tag_v_q[0]  <= m_en;
            tag_id_q[0] <= issue_id_q;
            for (int i = 1; i < int'(MACRO_LAT); i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end

            if (sample) begin
                rsp_valid <= 4'b0001 << sample_id;
                rsp_data  <= m_out;
            end else begin
                rsp_valid <= '0;
            end

            // Outstanding count spans from grant until the macro result is captured.
            case ({transfer, sample})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign busy = (state_q != StIdle) || (cnt_q != '0) || (rsp_valid != '0);

endmodule

// File: tb/tb_macro_lane_arbiter.sv
module tb_macro_lane_arbiter;

    localparam int DW = 4;
    localparam int L  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_valid;
    logic [4*DW-1:0] req_data;
    logic [3:0]    req_ready;
    logic          m_en;
    logic [DW-1:0] m_in;
    logic [DW-1:0] m_out;
    logic [3:0]    rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          drain;
    logic          drain_done;
    logic          busy;

    macro_lane_arbiter #(.DATA_W(DW), .MACRO_LAT(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .m_en       (m_en),
        .m_in       (m_in),
        .m_out      (m_out),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .drain      (drain),
        .drain_done (drain_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Hard-macro stand-in: echoes m_in after L cycles.
    logic [DW-1:0] mac [L];
    always @(posedge clk) begin
        mac[0] <= m_in;
        for (int i = 1; i < L; i++) mac[i] <= mac[i-1];
    end
    assign m_out = mac[L-1];

    // Reference model: mode 0 idle, 1 run, 2 drain; pending holds promised responses.
    typedef struct {
        int          due;
        int          id;
        logic [DW-1:0] data;
    } item_t;

    item_t         pend[$];
    int            mode = 0;
    int            rr = 0;
    int            cyc = 0;
    logic          exp_m_en = 1'b0;
    logic [DW-1:0] exp_m_in = '0;
    logic          exp_dd = 1'b0;
    logic          exp_zero = 1'b1;
    int            total = 0;
    int            passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
    endtask

    // One clock cycle: apply inputs, check all outputs against the model, advance the model.
    task automatic tick(input logic [3:0] rv, input logic [4*DW-1:0] rd, input logic dr,
                        input logic rs);
        logic [3:0]    er;
        logic [3:0]    erv;
        int            g;
        int            c;
        bit            quiet;
        item_t         it;
        req_valid = rv;
        req_data  = rd;
        drain     = dr;
        rst       = rs;
        #1;
        quiet = (pend.size() == 0);
        er = '0;
        g  = -1;
        if (!rs && mode == 1 && !dr) begin
            for (int k = 0; k < 4; k++) begin
                c = (rr + k) % 4;
                if (g < 0 && rv[c]) g = c;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("m_en", 32'(m_en), 32'(exp_m_en));
        chk("m_in", 32'(m_in), 32'(exp_m_in));
        erv = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            erv[pend[0].id] = 1'b1;
            chk("rsp_data", 32'(rsp_data), 32'(pend[0].data));
            void'(pend.pop_front());
        end else if (exp_zero) begin
            chk("rsp_data_rst", 32'(rsp_data), 32'h0);
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(erv));
        chk("drain_done", 32'(drain_done), 32'(exp_dd));
        chk("busy", 32'(busy), 32'((mode != 0) || (pend.size() > 0) || (erv != 0)));

        if (rs) begin
            mode     = 0;
            rr       = 0;
            pend.delete();
            exp_m_en = 1'b0;
            exp_m_in = '0;
            exp_dd   = 1'b0;
            exp_zero = 1'b1;
        end else begin
            exp_zero = 1'b0;
            exp_dd   = 1'b0;
            exp_m_en = (g >= 0);
            if (g >= 0) begin
                exp_m_in = rd[g*DW +: DW];
                rr       = (g + 1) % 4;
                it.due   = cyc + L + 2;
                it.id    = g;
                it.data  = rd[g*DW +: DW];
                pend.push_back(it);
            end
            case (mode)
                0: if (dr) mode = 2; else if (rv != 0) mode = 1;
                1: if (dr) mode = 2;
                default: if (quiet) begin mode = 0; exp_dd = 1'b1; end
            endcase
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0]      rv;
        logic [4*DW-1:0] rd;
        logic            dr;
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        drain = 1'b0;
        repeat (2) @(negedge clk);

        tick(4'b0000, 16'h0, 1'b0, 1'b1);
        tick(4'b0000, 16'h0, 1'b0, 1'b1);
        tick(4'b0000, 16'h0, 1'b0, 1'b0);
        tick(4'b0000, 16'h0, 1'b0, 1'b0);

        // Enter RUN, then all four requesting for 8 cycles from rr=0.
        tick(4'b1111, 16'h4321, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) tick(4'b1111, 16'(i * 16'h1111 + 16'h0123), 1'b0, 1'b0);
        repeat (7) tick(4'b0000, 16'h0, 1'b0, 1'b0);

        // Single request from lane 0 with 0xA.
        tick(4'b0001, 16'h000A, 1'b0, 1'b0);
        repeat (7) tick(4'b0000, 16'h0, 1'b0, 1'b0);

        // Lanes 1 and 3 only.
        repeat (6) tick(4'b1010, 16'h9C5B, 1'b0, 1'b0);
        repeat (6) tick(4'b0000, 16'h0, 1'b0, 1'b0);

        // Three transfers, then drain together with full requests; release drain mid-drain.
        repeat (3) tick(4'b1111, 16'hE7D6, 1'b0, 1'b0);
        tick(4'b1111, 16'hFFFF, 1'b1, 1'b0);
        repeat (3) tick(4'b1111, 16'h1234, 1'b1, 1'b0);
        repeat (10) tick(4'b0000, 16'h0, 1'b0, 1'b0);

        // Drain straight from IDLE.
        tick(4'b0000, 16'h0, 1'b1, 1'b0);
        repeat (4) tick(4'b0000, 16'h0, 1'b0, 1'b0);

        // Reset with two transactions in flight, then a fresh request.
        tick(4'b0100, 16'h0B00, 1'b0, 1'b0);
        tick(4'b0100, 16'h0B00, 1'b0, 1'b0);
        tick(4'b0100, 16'h0C00, 1'b0, 1'b0);
        tick(4'b0000, 16'h0, 1'b0, 1'b1);
        tick(4'b0010, 16'h0050, 1'b0, 1'b0);
        tick(4'b0010, 16'h0060, 1'b0, 1'b0);
        repeat (8) tick(4'b0000, 16'h0, 1'b0, 1'b0);

        // Randomized traffic with sporadic drain and reset.
        dr = 1'b0;
        for (int i = 0; i < 500; i++) begin
            rv = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rv = '0;
            rd = 16'($urandom);
            if ($urandom_range(0, 19) == 0) dr = ~dr;
            tick(rv, rd, dr, ($urandom_range(0, 149) == 0));
        end
        repeat (12) tick(4'b0000, 16'h0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
